// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, operand forwarding and MDU sequencing
// for the 5-stage pipelined MIPS core.
//
// Stall, flush and forward outputs are combinational from the inputs and the
// MDU sequencer state. The sequencer is a two-state FSM that tracks the
// multi-cycle multiply/divide unit so that dependent HI/LO reads and
// back-to-back MDU ops are held in decode until the result is ready.
//
// There is no valid/ready handshake here. MDSTARTD is accepted in the cycle
// where it is high, the sequencer is IDLE and decode is not stalled. MDBUSY
// is then high for exactly the op latency. MDDONE pulses for one cycle
// together with the falling edge of MDBUSY.
//
// dbg_state exposes the sequencer state (1 = BUSY) for checkers.
module pipe_hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] RSD,
    input  logic [4:0] RTD,
    input  logic       BRANCHD,
    input  logic       PCSRCD,
    input  logic       JMPD,
    input  logic       MDSTARTD,
    input  logic       MDDIVD,
    input  logic       MDREADD,
    input  logic [4:0] RSE,
    input  logic [4:0] RTE,
    input  logic [4:0] WRITEREGE,
    input  logic       WREGE,
    input  logic       M2REGE,
    input  logic [4:0] WRITEREGM,
    input  logic       WREGM,
    input  logic       M2REGM,
    input  logic [4:0] WRITEREGW,
    input  logic       WREGW,
    output logic       STALLF,
    output logic       STALLD,
    output logic       FLUSHD,
    output logic       FLUSHE,
    output logic       FORWARDAD,
    output logic       FORWARDBD,
    output logic [1:0] FORWARDAE,
    output logic [1:0] FORWARDBE,
    output logic       MDBUSY,
    output logic       MDDONE,
    output logic       dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;

    logic lwstall;
    logic brstall;
    logic mdstall;
    logic stall;

    // Register $0 is hardwired to zero, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    // Execute-stage operand selects: the younger M-stage result wins over W.
    always_comb begin
        FORWARDAE = 2'b00;
        if (hit(RSE, WRITEREGM) && WREGM)
            FORWARDAE = 2'b10;
        else if (hit(RSE, WRITEREGW) && WREGW)
            FORWARDAE = 2'b01;

        FORWARDBE = 2'b00;
        if (hit(RTE, WRITEREGM) && WREGM)
            FORWARDBE = 2'b10;
        else if (hit(RTE, WRITEREGW) && WREGW)
            FORWARDBE = 2'b01;
    end

    // Branch comparator can only take an M-stage ALU result; a load in M
    // has no data yet, and that case is covered by brstall instead.
    assign FORWARDAD = hit(RSD, WRITEREGM) && WREGM && !M2REGM;
    assign FORWARDBD = hit(RTD, WRITEREGM) && WREGM && !M2REGM;

    assign lwstall = M2REGE && (hit(RSD, WRITEREGE) || hit(RTD, WRITEREGE));

    assign brstall = BRANCHD &&
                     ((WREGE  && (hit(RSD, WRITEREGE) || hit(RTD, WRITEREGE))) ||
                      (M2REGM && (hit(RSD, WRITEREGM) || hit(RTD, WRITEREGM))));

    // Any MDU access in decode waits while an op is in flight; this also
    // holds off a new start issued in the completion cycle.
    assign mdstall = (MDREADD || MDSTARTD) && (state == BUSY);

    assign stall = lwstall || brstall || mdstall;

    // Reset forces bubbles into both pipeline registers and releases stalls.
    assign STALLD = stall && !RST;
    assign STALLF = stall && !RST;
    assign FLUSHE = stall || RST;
    assign FLUSHD = ((PCSRCD || JMPD) && !stall) || RST;

    assign dbg_state = (state == BUSY);

    // MDU sequencer: load the latency counter on an accepted start, count
    // down while BUSY, and pulse MDDONE as the op completes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            MDBUSY <= 1'b0;
            MDDONE <= 1'b0;
        end else begin
            MDDONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (MDSTARTD && !stall) begin
                        state  <= BUSY;
                        cnt    <= MDDIVD ? DIV_LOAD : MULT_LOAD;
                        MDBUSY <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state  <= IDLE;
                        MDBUSY <= 1'b0;
                        MDDONE <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    MDBUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus a randomized run
// checked against a cycle-indexed reference model of the hazard rules and
// of the MDU busy/done windows.
module tb_pipe_hazard_ctrl;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic       branchd, pcsrcd, jmpd, mdstartd, mddivd, mdreadd;
    logic       wrege, m2rege, wregm, m2regm, wregw;
    logic       stallf, stalld, flushd, flushe, fad, fbd, mdbusy, mddone, dbg_state;
    logic [1:0] fae, fbe;

    pipe_hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .CLK(clk), .RST(rst),
        .RSD(rsd), .RTD(rtd),
        .BRANCHD(branchd), .PCSRCD(pcsrcd), .JMPD(jmpd),
        .MDSTARTD(mdstartd), .MDDIVD(mddivd), .MDREADD(mdreadd),
        .RSE(rse), .RTE(rte),
        .WRITEREGE(wre), .WREGE(wrege), .M2REGE(m2rege),
        .WRITEREGM(wrm), .WREGM(wregm), .M2REGM(m2regm),
        .WRITEREGW(wrw), .WREGW(wregw),
        .STALLF(stallf), .STALLD(stalld), .FLUSHD(flushd), .FLUSHE(flushe),
        .FORWARDAD(fad), .FORWARDBD(fbd), .FORWARDAE(fae), .FORWARDBE(fbe),
        .MDBUSY(mdbusy), .MDDONE(mddone), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int passes = 0;

    // ---------------- reference model ----------------
    // MDU activity is modelled as absolute cycle windows: an op accepted in
    // cycle t is busy for cycles t+1 .. t+N and reports done in cycle t+N+1.
    int t       = 0;
    int busy_lo = -100;
    int busy_hi = -100;
    int done_at = -100;

    logic [1:0] e_fae, e_fbe;
    logic       e_fad, e_fbd, e_raw_stall, e_stall, e_flushd, e_flushe, e_busy, e_done;

    function automatic logic dep(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    task automatic model_reset();
        busy_lo = -100;
        busy_hi = -100;
        done_at = -100;
    endtask

    task automatic model_comb();
        logic lw, br, md;
        e_fae = (dep(rse, wrm) && wregm) ? 2'd2 : (dep(rse, wrw) && wregw) ? 2'd1 : 2'd0;
        e_fbe = (dep(rte, wrm) && wregm) ? 2'd2 : (dep(rte, wrw) && wregw) ? 2'd1 : 2'd0;
        e_fad = dep(rsd, wrm) && wregm && !m2regm;
        e_fbd = dep(rtd, wrm) && wregm && !m2regm;
        e_busy = (t >= busy_lo) && (t <= busy_hi);
        e_done = (t == done_at);
        lw = m2rege && (dep(rsd, wre) || dep(rtd, wre));
        br = branchd && ((wrege && (dep(rsd, wre) || dep(rtd, wre))) ||
                         (m2regm && (dep(rsd, wrm) || dep(rtd, wrm))));
        md = (mdreadd || mdstartd) && e_busy;
        e_raw_stall = lw || br || md;
        e_stall  = rst ? 1'b0 : e_raw_stall;
        e_flushe = rst ? 1'b1 : e_raw_stall;
        e_flushd = rst ? 1'b1 : ((pcsrcd || jmpd) && !e_raw_stall);
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        rsd = 0; rtd = 0; rse = 0; rte = 0; wre = 0; wrm = 0; wrw = 0;
        branchd = 0; pcsrcd = 0; jmpd = 0; mdstartd = 0; mddivd = 0; mdreadd = 0;
        wrege = 0; m2rege = 0; wregm = 0; m2regm = 0; wregw = 0;
    endtask

    // Advance one clock; the model records an MDU acceptance first.
    task automatic tick();
        int n;
        model_comb();
        if (!rst && mdstartd && !e_raw_stall && !e_busy) begin
            n = mddivd ? DIV_LAT : MULT_LAT;
            busy_lo = t + 1;
            busy_hi = t + n;
            done_at = t + n + 1;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        tick();
        tick();
        checks++; if (mdbusy !== 1'b0) $display("FAIL rst_mdbusy: got %b want 0", mdbusy); else passes++;
        checks++; if (mddone !== 1'b0) $display("FAIL rst_mddone: got %b want 0", mddone); else passes++;
        checks++; if (dbg_state !== 1'b0) $display("FAIL rst_state: got %b want 0", dbg_state); else passes++;
        checks++; if (stalld !== 1'b0 || stallf !== 1'b0) $display("FAIL rst_stall: got %b%b want 00", stallf, stalld); else passes++;
        checks++; if (flushd !== 1'b1 || flushe !== 1'b1) $display("FAIL rst_flush: got %b%b want 11", flushd, flushe); else passes++;
        rst = 1'b0;
        tick();
        checks++; if (flushd !== 1'b0 || flushe !== 1'b0) $display("FAIL post_rst_flush: got %b%b want 00", flushd, flushe); else passes++;
    endtask

    task automatic test_load_use();
        clear_inputs();
        m2rege = 1; wrege = 1; wre = 5; rsd = 5;
        #1;
        checks++; if ({stallf, stalld, flushe} !== 3'b111) $display("FAIL lu_stall: got %b want 111", {stallf, stalld, flushe}); else passes++;
        checks++; if (flushd !== 1'b0) $display("FAIL lu_flushd: got %b want 0", flushd); else passes++;
        tick();
        clear_inputs();
        rsd = 5; wrm = 5; wregm = 1; m2regm = 1;
        #1;
        checks++; if ({stallf, stalld, flushe} !== 3'b000) $display("FAIL lu_release: got %b want 000", {stallf, stalld, flushe}); else passes++;
        tick();
        clear_inputs();
        m2rege = 1; wrege = 1; wre = 0; rsd = 0; rtd = 0;
        #1;
        checks++; if (stalld !== 1'b0) $display("FAIL lu_reg0: got %b want 0", stalld); else passes++;
        tick();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        rse = 7; wrm = 7; wregm = 1; wrw = 7; wregw = 1;
        #1;
        checks++; if (fae !== 2'b10) $display("FAIL fwd_m_prio: got %b want 10", fae); else passes++;
        wregm = 0;
        #1;
        checks++; if (fae !== 2'b01) $display("FAIL fwd_w: got %b want 01", fae); else passes++;
        rse = 0; wrm = 0; wrw = 0; wregm = 1;
        #1;
        checks++; if (fae !== 2'b00) $display("FAIL fwd_reg0: got %b want 00", fae); else passes++;
        rte = 9; wrw = 9; wregw = 1; wrm = 8;
        #1;
        checks++; if (fbe !== 2'b01) $display("FAIL fwd_be_w: got %b want 01", fbe); else passes++;
        rtd = 8; m2regm = 1;
        #1;
        checks++; if (fbd !== 1'b0) $display("FAIL fwd_bd_load: got %b want 0", fbd); else passes++;
        m2regm = 0;
        #1;
        checks++; if (fbd !== 1'b1) $display("FAIL fwd_bd_alu: got %b want 1", fbd); else passes++;
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        branchd = 1; pcsrcd = 1; rsd = 3; wre = 3; wrege = 1;
        #1;
        checks++; if (stalld !== 1'b1) $display("FAIL br_stall_e: got %b want 1", stalld); else passes++;
        checks++; if (flushd !== 1'b0) $display("FAIL br_flushd_hold: got %b want 0", flushd); else passes++;
        tick();
        wrege = 0; wre = 0; wrm = 3; wregm = 1; m2regm = 0;
        #1;
        checks++; if (stalld !== 1'b0) $display("FAIL br_release: got %b want 0", stalld); else passes++;
        checks++; if (fad !== 1'b1) $display("FAIL br_fad: got %b want 1", fad); else passes++;
        checks++; if (flushd !== 1'b1) $display("FAIL br_taken_flush: got %b want 1", flushd); else passes++;
        pcsrcd = 0;
        #1;
        checks++; if (flushd !== 1'b0) $display("FAIL br_not_taken: got %b want 0", flushd); else passes++;
        m2regm = 1;
        #1;
        checks++; if (stalld !== 1'b1) $display("FAIL br_load_m: got %b want 1", stalld); else passes++;
        tick();
        // lwstall coinciding with a taken branch: the stall wins
        clear_inputs();
        m2rege = 1; wre = 4; rtd = 4; pcsrcd = 1;
        #1;
        checks++; if (stalld !== 1'b1 || flushd !== 1'b0) $display("FAIL lw_vs_br: got stall=%b flushd=%b want 1/0", stalld, flushd); else passes++;
        clear_inputs();
        jmpd = 1;
        #1;
        checks++; if (flushd !== 1'b1 || stalld !== 1'b0) $display("FAIL jump_flush: got flushd=%b stall=%b want 1/0", flushd, stalld); else passes++;
        tick();
        clear_inputs();
    endtask

    task automatic test_divide();
        int busy_n, stall_n, done_n;
        bit seen_idle;
        busy_n = 0; stall_n = 0; done_n = 0; seen_idle = 0;
        clear_inputs();
        mdstartd = 1; mddivd = 1;
        #1;
        checks++; if (stalld !== 1'b0) $display("FAIL div_accept: got %b want 0", stalld); else passes++;
        tick();
        mdstartd = 0; mddivd = 0; mdreadd = 1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (mdbusy === 1'b1) busy_n++;
            if (stalld === 1'b1) stall_n++;
            if (mddone === 1'b1) done_n++;
            if (mdbusy !== 1'b1 && !seen_idle) begin
                seen_idle = 1;
                checks++; if (stalld !== 1'b0) $display("FAIL div_read_release: got %b want 0", stalld); else passes++;
                checks++; if (mddone !== 1'b1) $display("FAIL div_done_edge: got %b want 1", mddone); else passes++;
            end
            tick();
        end
        checks++; if (!seen_idle) $display("FAIL div_timeout: got busy past 40 cycles want idle"); else passes++;
        checks++; if (busy_n != DIV_LAT) $display("FAIL div_busy_len: got %0d want %0d", busy_n, DIV_LAT); else passes++;
        checks++; if (stall_n != DIV_LAT) $display("FAIL div_stall_len: got %0d want %0d", stall_n, DIV_LAT); else passes++;
        checks++; if (done_n != 1) $display("FAIL div_done_cnt: got %0d want 1", done_n); else passes++;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [0:11] exp_busy;
        logic [0:11] exp_stall;
        logic [0:11] exp_done;
        exp_busy  = 12'b011110111100;
        exp_stall = 12'b011110000000;
        exp_done  = 12'b000001000010;
        clear_inputs();
        for (int c = 0; c < 12; c++) begin
            mdstartd = (c <= 5);
            mddivd = 0;
            #1;
            checks++; if (mdbusy !== exp_busy[c]) $display("FAIL b2b_busy c%0d: got %b want %b", c, mdbusy, exp_busy[c]); else passes++;
            checks++; if (stalld !== exp_stall[c]) $display("FAIL b2b_stall c%0d: got %b want %b", c, stalld, exp_stall[c]); else passes++;
            checks++; if (mddone !== exp_done[c]) $display("FAIL b2b_done c%0d: got %b want %b", c, mddone, exp_done[c]); else passes++;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_divide();
        int done_n, busy_n;
        done_n = 0; busy_n = 0;
        clear_inputs();
        mdstartd = 1; mddivd = 1;
        #1;
        tick();
        mdstartd = 0; mddivd = 0;
        // busy cycle k holds count DIV_LAT-k; count 10 is busy cycle 22
        for (int k = 1; k < 22; k++) tick();
        #1;
        checks++; if (mdbusy !== 1'b1) $display("FAIL mid_busy_pre: got %b want 1", mdbusy); else passes++;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (mdbusy !== 1'b0) $display("FAIL mid_async_busy: got %b want 0", mdbusy); else passes++;
        checks++; if (flushd !== 1'b1 || flushe !== 1'b1) $display("FAIL mid_flush: got %b%b want 11", flushd, flushe); else passes++;
        checks++; if (stalld !== 1'b0) $display("FAIL mid_stall: got %b want 0", stalld); else passes++;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (mddone === 1'b1) done_n++;
            if (mdbusy === 1'b1) busy_n++;
            tick();
        end
        checks++; if (done_n != 0) $display("FAIL mid_no_done: got %0d want 0", done_n); else passes++;
        checks++; if (busy_n != 0) $display("FAIL mid_no_busy: got %0d want 0", busy_n); else passes++;
    endtask

    task automatic test_random();
        clear_inputs();
        for (int i = 0; i < 400; i++) begin
            rsd = 5'($urandom_range(0, 3)); rtd = 5'($urandom_range(0, 3));
            rse = 5'($urandom_range(0, 3)); rte = 5'($urandom_range(0, 3));
            wre = 5'($urandom_range(0, 3)); wrm = 5'($urandom_range(0, 3));
            wrw = 5'($urandom_range(0, 3));
            wrege = 1'($urandom_range(0, 1)); m2rege = ($urandom_range(0, 3) == 0);
            wregm = 1'($urandom_range(0, 1)); m2regm = ($urandom_range(0, 3) == 0);
            wregw = 1'($urandom_range(0, 1));
            branchd = ($urandom_range(0, 2) == 0); pcsrcd = 1'($urandom_range(0, 1));
            jmpd = ($urandom_range(0, 5) == 0);
            mdstartd = ($urandom_range(0, 5) == 0); mddivd = ($urandom_range(0, 3) == 0);
            mdreadd = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 99) == 0);
            if (rst) model_reset();
            #1;
            model_comb();
            checks++; if (fae !== e_fae) $display("FAIL rnd_fae i%0d: got %b want %b", i, fae, e_fae); else passes++;
            checks++; if (fbe !== e_fbe) $display("FAIL rnd_fbe i%0d: got %b want %b", i, fbe, e_fbe); else passes++;
            checks++; if (fad !== e_fad || fbd !== e_fbd) $display("FAIL rnd_fd i%0d: got %b%b want %b%b", i, fad, fbd, e_fad, e_fbd); else passes++;
            checks++; if (stalld !== e_stall || stallf !== e_stall) $display("FAIL rnd_stall i%0d: got %b%b want %b", i, stallf, stalld, e_stall); else passes++;
            checks++; if (flushd !== e_flushd) $display("FAIL rnd_flushd i%0d: got %b want %b", i, flushd, e_flushd); else passes++;
            checks++; if (flushe !== e_flushe) $display("FAIL rnd_flushe i%0d: got %b want %b", i, flushe, e_flushe); else passes++;
            checks++; if (mdbusy !== e_busy || dbg_state !== e_busy) $display("FAIL rnd_busy i%0d: got %b/%b want %b", i, mdbusy, dbg_state, e_busy); else passes++;
            checks++; if (mddone !== e_done) $display("FAIL rnd_done i%0d: got %b want %b", i, mddone, e_done); else passes++;
            tick();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_divide();
        test_back_to_back();
        test_reset_mid_divide();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
